// File: rtl/shift_pkg.sv
// Shared types for the shifter writeback queue: entry layout,
// operand size codes, WFLAGS bit positions and byte-enable decode.
package shift_pkg;

    localparam logic [1:0] SZ_8  = 2'b00;
    localparam logic [1:0] SZ_16 = 2'b01;
    localparam logic [1:0] SZ_32 = 2'b10;
    localparam logic [1:0] SZ_64 = 2'b11;

    localparam int FLAG_OVR  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_COUT = 2;
    localparam int FLAG_SIGN = 3;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  dst;
        logic [1:0]  size;
        logic [3:0]  flags;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [7:0] size_to_be(input logic [1:0] sz);
        logic [7:0] be;
        case (sz)
            SZ_8:    be = 8'h01;
            SZ_16:   be = 8'h03;
            SZ_32:   be = 8'h0F;
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/shift_result_queue_sync_fifo.sv
// sync_fifo: power-of-two circular buffer; a push into a full
// queue is only accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_count   = r_cnt;
    assign o_rdata   = r_mem[r_rd];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/shift_result_queue.sv
// Writeback queue behind the 64-bit shifter. Optional same-cycle
// bypass of an empty queue is enabled by SHIFT_RESULT_BYPASS_EN.
module shift_result_queue
    import shift_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SKID  = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   RDY,
    input  logic [63:0]            R,
    input  logic [3:0]             DSTo,
    input  logic [1:0]             SR,
    input  logic                   OVR,
    input  logic                   ZERO,
    input  logic                   COUT,
    input  logic                   SIGN,
    output logic                   WREQ,
    input  logic                   WACK,
    output logic [63:0]            WDATA,
    output logic [3:0]             WDST,
    output logic [7:0]             WBE,
    output logic [3:0]             WFLAGS,
    output logic                   ISSUE_STALL,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVF_ERR
);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t w_in;
    entry_t w_head;
    entry_t w_out;
    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_byp;
    logic   w_byp_take;
    logic   r_ovf;

    assign w_in.data             = R;
    assign w_in.dst              = DSTo;
    assign w_in.size             = SR;
    assign w_in.flags[FLAG_OVR]  = OVR;
    assign w_in.flags[FLAG_ZERO] = ZERO;
    assign w_in.flags[FLAG_COUT] = COUT;
    assign w_in.flags[FLAG_SIGN] = SIGN;

`ifdef SHIFT_RESULT_BYPASS_EN
    assign w_byp = w_empty & RDY;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed result acknowledged in the same cycle is never stored.
    assign w_byp_take = w_byp & WACK;
    assign w_pop      = WACK & ~w_empty;
    assign w_push     = RDY & ~w_byp_take & (~w_full | w_pop);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in),
        .o_rdata (w_head),
        .o_count (COUNT),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head fields are forced to zero while idle so reset state is clean
    // without clearing the storage array.
    assign w_out       = w_byp ? w_in : w_head;
    assign WREQ        = ~w_empty | w_byp;
    assign WDATA       = WREQ ? w_out.data  : '0;
    assign WDST        = WREQ ? w_out.dst   : '0;
    assign WFLAGS      = WREQ ? w_out.flags : '0;
    assign WBE         = WREQ ? size_to_be(w_out.size) : '0;
    assign ISSUE_STALL = (COUNT >= CW'(DEPTH - SKID));
    assign OVF_ERR     = r_ovf;

    // Sticky overflow: a result arrived with no room and no pop to free one.
    always_ff @(posedge CLK) begin
        if (RESET) r_ovf <= 1'b0;
        else if (RDY & w_full & ~w_pop) r_ovf <= 1'b1;
    end

endmodule
